// File: rtl/adc_frame_tx.sv
// Captures one scan of 12-bit ADC samples after a sync pulse and streams it as a raw
// Ethernet frame of 32-bit words on the MAC transmit FIFO interface.
module adc_frame_tx #(
    parameter int          SAMPLES  = 256,
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0001_0203_0405,
    parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sync,
    input  logic [11:0] i_smp_data,
    input  logic        i_smp_vld,
    output logic [31:0] o_tx_data,
    output logic        o_tx_vld,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic [1:0]  o_tx_mod,
    input  logic        i_tx_rdy,
    output logic        o_busy,
    output logic [15:0] o_seq,
    output logic [15:0] o_drop_cnt
);

    localparam int WORDS = SAMPLES / 2;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = $clog2(SAMPLES + 1);
    localparam int FW    = $clog2(WORDS + 4);

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(WORDS - 1);
    localparam logic [FW-1:0] IDX_W3   = FW'(3);
    localparam logic [FW-1:0] IDX_LAST = FW'(WORDS + 3);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HDR,
        PAYLOAD
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] smp_cnt;
    logic [11:0]   smp_hold;
    logic [31:0]   buf_mem [WORDS];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;

    logic [FW-1:0] word_idx;
    logic [FW-1:0] nxt_idx;
    logic [31:0]   nxt_data;

    logic          capture;
    logic          capture_done;
    logic          accept;
    logic          frame_end;
    logic          consume;

    assign capture      = (state == CAPTURE) && i_smp_vld;
    assign capture_done = capture && (smp_cnt == CNT_LAST);
    assign accept       = o_tx_vld && i_tx_rdy;
    assign frame_end    = accept && o_tx_eop;
    // Loading the next payload word from the prefetch register, starting with the W3 handoff.
    assign consume      = accept && !o_tx_eop && (word_idx >= IDX_W3);
    assign wr_addr      = AW'(smp_cnt >> 1);

    assign o_tx_mod = 2'b00;
    assign o_busy   = (state != IDLE);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned
        // (that would infer a latch).
        state_nxt = state;
        case (state)
            IDLE:    if (i_sync)                         state_nxt = CAPTURE;
            CAPTURE: if (capture_done)                   state_nxt = HDR;
            HDR:     if (accept && (word_idx == IDX_W3)) state_nxt = PAYLOAD;
            PAYLOAD: if (frame_end)                      state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_cnt <= '0;
        end else if ((state == IDLE) && i_sync) begin
            smp_cnt <= '0;
        end else if (capture) begin
            smp_cnt <= smp_cnt + CW'(1);
        end
    end

    // NOTE: the sample buffer and its read register carry no reset; every word is
    // rewritten during capture before it is read, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (capture && !smp_cnt[0]) begin
            smp_hold <= i_smp_data;
        end
        if (capture && smp_cnt[0]) begin
            buf_mem[wr_addr] <= {4'h0, smp_hold, 4'h0, i_smp_data};
        end
        rd_data <= buf_mem[rd_addr];
    end

    // Show-ahead read: rd_data always holds the next payload word to present, and the
    // address jumps ahead on the same edge that word is taken, so there are no bubbles.
    assign rd_addr = (consume && (rd_ptr != PTR_LAST)) ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if ((state == IDLE) && i_sync) begin
            rd_ptr <= '0;
        end else begin
            rd_ptr <= rd_addr;
        end
    end

    // ------------------------------------------------------------------ transmit
    always_comb begin
        nxt_idx = word_idx + FW'(1);
        case (nxt_idx)
            FW'(1):  nxt_data = {DST_MAC[15:0], SRC_MAC[47:32]};
            FW'(2):  nxt_data = SRC_MAC[31:0];
            FW'(3):  nxt_data = {ETH_TYPE, o_seq};
            default: nxt_data = rd_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_tx_data <= '0;
            o_tx_vld  <= 1'b0;
            o_tx_sop  <= 1'b0;
            o_tx_eop  <= 1'b0;
            word_idx  <= '0;
        end else if (capture_done) begin
            o_tx_data <= DST_MAC[47:16];
            o_tx_vld  <= 1'b1;
            o_tx_sop  <= 1'b1;
            o_tx_eop  <= 1'b0;
            word_idx  <= '0;
        end else if (accept) begin
            if (o_tx_eop) begin
                o_tx_vld <= 1'b0;
                o_tx_sop <= 1'b0;
                o_tx_eop <= 1'b0;
            end else begin
                o_tx_data <= nxt_data;
                o_tx_sop  <= 1'b0;
                o_tx_eop  <= (nxt_idx == IDX_LAST);
                word_idx  <= nxt_idx;
            end
        end
    end

    // ------------------------------------------------------------------ counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_seq      <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (frame_end) begin
                o_seq <= o_seq + 16'd1;
            end
            // A sync on the eop edge still sees PAYLOAD and is counted as a drop.
            if (i_sync && (state != IDLE) && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed self-checking bench for adc_frame_tx with SAMPLES=22 (15-word frames).
module tb_adc_frame_tx;

    localparam int SAMPLES = 22;
    localparam int NW      = 4 + SAMPLES / 2;

    logic        clk;
    logic        reset;
    logic        i_sync;
    logic [11:0] i_smp_data;
    logic        i_smp_vld;
    logic [31:0] o_tx_data;
    logic        o_tx_vld;
    logic        o_tx_sop;
    logic        o_tx_eop;
    logic [1:0]  o_tx_mod;
    logic        i_tx_rdy;
    logic        o_busy;
    logic [15:0] o_seq;
    logic [15:0] o_drop_cnt;

    int tests = 0;
    int fails = 0;

    adc_frame_tx #(.SAMPLES(SAMPLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_sync     (i_sync),
        .i_smp_data (i_smp_data),
        .i_smp_vld  (i_smp_vld),
        .o_tx_data  (o_tx_data),
        .o_tx_vld   (o_tx_vld),
        .o_tx_sop   (o_tx_sop),
        .o_tx_eop   (o_tx_eop),
        .o_tx_mod   (o_tx_mod),
        .i_tx_rdy   (i_tx_rdy),
        .o_busy     (o_busy),
        .o_seq      (o_seq),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame word k given the sequence number and the first sample value.
    function automatic logic [31:0] exp_word(input int k, input logic [15:0] seq,
                                             input logic [11:0] first);
        logic [11:0] a;
        logic [11:0] b;
        case (k)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_0001;
            2:       return 32'h0203_0405;
            3:       return {16'h88B5, seq};
            default: begin
                a = first + 12'(2 * (k - 4));
                b = a + 12'd1;
                return {4'h0, a, 4'h0, b};
            end
        endcase
    endfunction

    task automatic do_sync();
        i_sync = 1'b1;
        @(negedge clk);
        i_sync = 1'b0;
    endtask

    // Samples first, first+1, ...; optional idle gaps; optional extra sync at sample sync_at.
    task automatic drive_samples(input logic [11:0] first, input bit gaps, input int sync_at);
        for (int i = 0; i < SAMPLES; i++) begin
            if (gaps && (i % 4 == 1)) begin
                i_smp_vld  = 1'b0;
                i_smp_data = 12'hBAD;
                i_sync     = 1'b0;
                @(negedge clk);
            end
            i_smp_vld  = 1'b1;
            i_smp_data = first + 12'(i);
            i_sync     = (i == sync_at);
            @(negedge clk);
        end
        i_smp_vld  = 1'b0;
        i_smp_data = 12'h000;
        i_sync     = 1'b0;
    endtask

    // Checks every presented word each cycle; returns early when word abort_at is on the bus.
    task automatic collect(input string name, input logic [15:0] seq, input logic [11:0] first,
                           input bit toggle, input int drop_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit dropped = 1'b0;
        logic [15:0] seq_next;
        while (idx < NW && idx != abort_at) begin
            i_tx_rdy = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            i_sync   = 1'b0;
            if (idx == drop_at && !dropped) begin
                i_sync  = 1'b1;
                dropped = 1'b1;
            end
            check($sformatf("%s w%0d vld", name, idx), 32'(o_tx_vld), 32'd1);
            check($sformatf("%s w%0d data", name, idx), o_tx_data, exp_word(idx, seq, first));
            check($sformatf("%s w%0d sop", name, idx), 32'(o_tx_sop), 32'(idx == 0));
            check($sformatf("%s w%0d eop", name, idx), 32'(o_tx_eop), 32'(idx == NW - 1));
            if (i_tx_rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        i_sync   = 1'b0;
        i_tx_rdy = 1'b1;
        if (idx == NW) begin
            seq_next = seq + 16'd1;
            check({name, " post vld"}, 32'(o_tx_vld), 32'd0);
            check({name, " post busy"}, 32'(o_busy), 32'd0);
            check({name, " post seq"}, 32'(o_seq), 32'(seq_next));
            check({name, " mod"}, 32'(o_tx_mod), 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_sync     = 1'b0;
        i_smp_data = 12'h000;
        i_smp_vld  = 1'b0;
        i_tx_rdy   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst vld", 32'(o_tx_vld), 32'd0);
        check("rst sop", 32'(o_tx_sop), 32'd0);
        check("rst eop", 32'(o_tx_eop), 32'd0);
        check("rst data", o_tx_data, 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst seq", 32'(o_seq), 32'd0);
        check("rst drop", 32'(o_drop_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // A: back-to-back samples, MAC always ready
        do_sync();
        check("A busy", 32'(o_busy), 32'd1);
        drive_samples(12'h001, 1'b0, -1);
        collect("A", 16'h0000, 12'h001, 1'b0, -1, -1);

        // B: ready toggling 1,0,0,1
        do_sync();
        drive_samples(12'h031, 1'b0, -1);
        collect("B", 16'h0001, 12'h031, 1'b1, -1, -1);
        check("B drop", 32'(o_drop_cnt), 32'd0);

        // C: extra syncs during CAPTURE and PAYLOAD
        do_sync();
        drive_samples(12'h201, 1'b0, 5);
        collect("C", 16'h0002, 12'h201, 1'b0, 8, -1);
        check("C drop", 32'(o_drop_cnt), 32'd2);

        // D/E: sequence number wrap
        force dut.o_seq = 16'hFFFF;
        #1;
        release dut.o_seq;
        check("D seq preload", 32'(o_seq), 32'h0000_FFFF);
        @(negedge clk);
        do_sync();
        drive_samples(12'h301, 1'b0, -1);
        collect("D", 16'hFFFF, 12'h301, 1'b0, -1, -1);
        do_sync();
        drive_samples(12'h401, 1'b0, -1);
        collect("E", 16'h0000, 12'h401, 1'b1, -1, -1);

        // F: reset while payload word 6 is on the bus
        do_sync();
        drive_samples(12'h501, 1'b0, -1);
        collect("F", 16'h0001, 12'h501, 1'b1, -1, 6);
        check("F vld before rst", 32'(o_tx_vld), 32'd1);
        reset = 1'b1;
        #1;
        check("F rst vld", 32'(o_tx_vld), 32'd0);
        check("F rst busy", 32'(o_busy), 32'd0);
        check("F rst seq", 32'(o_seq), 32'd0);
        check("F rst drop", 32'(o_drop_cnt), 32'd0);
        check("F rst eop", 32'(o_tx_eop), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // G: samples in IDLE and on the sync cycle are ignored; gaps during capture
        i_smp_vld  = 1'b1;
        i_smp_data = 12'hEEE;
        repeat (3) @(negedge clk);
        i_smp_data = 12'hEEF;
        check("G idle busy", 32'(o_busy), 32'd0);
        do_sync();
        drive_samples(12'h601, 1'b1, -1);
        collect("G", 16'h0000, 12'h601, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
